irq_trap_ctrl: RTL

//  Sequences interrupt entry, WFI sleep and MRET return for the IF stage PC mux.

---
 rtl/irq_pkg.sv | 15 +
 rtl/irq_prio_enc.sv | 31 +++
 rtl/irq_trap_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt/trap sequencer.
//   irq_state_e : sequencer states (RUN, SLEEP, TRAP, HANDLER)
//   CAUSE_MEI   : mcause value for a machine external interrupt
package irq_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SLEEP   = 2'd1,
    TRAP    = 2'd2,
    HANDLER = 2'd3
  } irq_state_e;

  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: index 0 is the highest priority.
// Ports:
//   req   in  NUM_SRC  request vector
//   valid out 1        any request present
//   idx   out ID_W     index of the winning request
//   grant out NUM_SRC  one-hot grant of the winning request
module irq_prio_enc #(
  parameter int NUM_SRC = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [ID_W-1:0]    idx,
  output logic [NUM_SRC-1:0] grant
);

  always_comb begin
    valid = |req;
    idx   = '0;
    grant = '0;
    // Scan from the top down so the lowest set index is written last and wins.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx      = ID_W'(i);
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_trap_ctrl.sv
// Interrupt entry / WFI sleep / MRET return sequencer for the IF-stage PC mux.
// Samples level-sensitive peripheral requests, arbitrates them by fixed priority
// and drives the IF controls, the CSR mepc/mcause/mstatus updates and the flush.
// Optional build macro: IRQ_SYNC_EN adds a 2-flop synchronizer on every irq_src
// bit ahead of the pending register (+2 cycles of entry latency).
// Ports:
//   clk, rst (async, active-low)
//   irq_src, src_en            peripheral levels and per-source enables
//   csr_mie, csr_meie          mstatus.MIE, mie.MEIE
//   stall, wfi_id, mret_id     pipeline stall, WFI/MRET decoded in ID
//   redirect, redirect_pc      EX branch/jump taken and its target
//   if_pc                      current IF PC
//   interrupt, wfi_hold, mret_go                   IF controls
//   mepc_we, mepc_wdata, mcause_wdata              CSR trap write
//   mstatus_save, mstatus_rest                     CSR mstatus stack ops
//   irq_ack, irq_id                                serviced source
//   trap_cnt, sleep_cnt                            event counters
module irq_trap_ctrl
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] src_en,
  input  logic               csr_mie,
  input  logic               csr_meie,
  input  logic               stall,
  input  logic               wfi_id,
  input  logic               mret_id,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic [31:0]        if_pc,
  output logic               interrupt,
  output logic               wfi_hold,
  output logic               mret_go,
  output logic               mepc_we,
  output logic [31:0]        mepc_wdata,
  output logic [31:0]        mcause_wdata,
  output logic               mstatus_save,
  output logic               mstatus_rest,
  output logic [NUM_SRC-1:0] irq_ack,
  output logic [ID_W-1:0]    irq_id,
  output logic [31:0]        trap_cnt,
  output logic [31:0]        sleep_cnt
);

  irq_state_e         state;
  logic [NUM_SRC-1:0] src_s;
  logic [NUM_SRC-1:0] pend;
  logic               pend_any;
  logic [ID_W-1:0]    enc_idx;
  logic [NUM_SRC-1:0] enc_grant;
  logic               take;
  logic               trap_q;
  logic               hold_q;
  logic [31:0]        mepc_q;
  logic [ID_W-1:0]    id_q;
  logic [NUM_SRC-1:0] ack_q;
  logic [31:0]        trap_cnt_q;
  logic [31:0]        sleep_cnt_q;

`ifdef IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync1;
  logic [NUM_SRC-1:0] sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_src;
      sync2 <= sync1;
    end
  end

  assign src_s = sync2;
`else
  assign src_s = irq_src;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= '0;
    end else begin
      pend <= src_s & src_en;
    end
  end

  irq_prio_enc #(
    .NUM_SRC(NUM_SRC),
    .ID_W   (ID_W)
  ) u_prio_enc (
    .req  (pend),
    .valid(pend_any),
    .idx  (enc_idx),
    .grant(enc_grant)
  );

  assign take = pend_any & csr_meie & csr_mie;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      trap_q      <= 1'b0;
      hold_q      <= 1'b0;
      mepc_q      <= '0;
      id_q        <= '0;
      ack_q       <= '0;
      trap_cnt_q  <= '0;
      sleep_cnt_q <= '0;
    end else begin
      // TRAP lasts exactly one cycle, so the trap strobe is cleared by default.
      trap_q <= 1'b0;
      if (state == SLEEP) begin
        sleep_cnt_q <= sleep_cnt_q + 32'd1;
      end
      case (state)
        RUN: begin
          // MRET wins over a pending trap; the trap is re-evaluated next cycle.
          if (!stall && !mret_id) begin
            if (take) begin
              state  <= TRAP;
              trap_q <= 1'b1;
              mepc_q <= redirect ? redirect_pc : if_pc;
              id_q   <= enc_idx;
              ack_q  <= enc_grant;
            end else if (wfi_id) begin
              state  <= SLEEP;
              hold_q <= 1'b1;
            end
          end
        end
        SLEEP: begin
          // Wake ignores MIE; MIE only decides between trapping and resuming.
          if (!stall && pend_any && csr_meie) begin
            hold_q <= 1'b0;
            if (csr_mie) begin
              state  <= TRAP;
              trap_q <= 1'b1;
              mepc_q <= if_pc;
              id_q   <= enc_idx;
              ack_q  <= enc_grant;
            end else begin
              state <= RUN;
            end
          end
        end
        TRAP: begin
          // Count commits on leaving TRAP so a reset during TRAP commits nothing.
          state      <= HANDLER;
          trap_cnt_q <= trap_cnt_q + 32'd1;
        end
        HANDLER: begin
          if (!stall && mret_id) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign interrupt    = trap_q;
  assign mepc_we      = trap_q;
  assign mstatus_save = trap_q;
  assign irq_ack      = trap_q ? ack_q : '0;
  assign wfi_hold     = hold_q;
  assign mepc_wdata   = mepc_q;
  assign mcause_wdata = CAUSE_MEI;
  assign irq_id       = id_q;
  assign trap_cnt     = trap_cnt_q;
  assign sleep_cnt    = sleep_cnt_q;

  // Combinational so IF can load mepc in the same cycle; held low during reset.
  assign mret_go      = rst & mret_id & ~stall & ((state == RUN) | (state == HANDLER));
  assign mstatus_rest = mret_go;

endmodule
